axi_bridge_ip_rx: RTL and testbench

- Receive-side counterpart of the AXI bridge TX path.
- Accepts link beats (payload word plus valid-byte count plus last flag) from the UCIe adapter-side link interface and rebuilds an AXI4-Stream master stream (tdata/tkeep/tlast/tuser).
- Generates monotonic tkeep from the byte count and validates beat legality.
- Buffers beats in a small FIFO and cleanly aborts malformed packets.

---
 rtl/axi_bridge_ip_rx_pkg.sv | 52 +++++
 rtl/axi_bridge_rx_fifo.sv | 87 ++++++++
 rtl/axi_bridge_ip_rx.sv | 151 +++++++++++++++
 tb/tb_axi_bridge_ip_rx.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_ip_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module : axi_bridge_ip_rx_pkg -- shared types and beat-legality helpers
// Rev    : 1.0
// ----------------------------------------------------------------------------
package axi_bridge_ip_rx_pkg;

  localparam int MAX_KEEP_W = 256;
  localparam int MAX_CNT_W  = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } rx_state_e;

  // Sideband bits that sit above {tkeep, tdata} in each FIFO word.
  typedef struct packed {
    logic tuser;
    logic tlast;
  } rx_beat_t;

  function automatic logic [MAX_KEEP_W-1:0] keep_from_nbytes(
    input logic [MAX_CNT_W-1:0] nbytes,
    input int                   nbytes_max
  );
    logic [MAX_KEEP_W-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if ((i < int'(nbytes)) && (i < nbytes_max)) begin
        k[i] = 1'b1;
      end
    end
    return k;
  endfunction

  function automatic logic nbytes_illegal_f(
    input logic [MAX_CNT_W-1:0] nbytes,
    input int                   nbytes_max,
    input logic                 is_last
  );
    int n;
    n = int'(nbytes);
    if ((n == 0) || (n > nbytes_max)) begin
      return 1'b1;
    end
    return !is_last && (n != nbytes_max);
  endfunction

endpackage : axi_bridge_ip_rx_pkg
`default_nettype wire

// File: rtl/axi_bridge_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module : axi_bridge_rx_fifo -- first-word-fall-through FIFO, head held in flops
// Rev    : 1.0
// ----------------------------------------------------------------------------
module axi_bridge_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_next_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [OW-1:0]    mem_cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic          do_pop;
  logic          out_free;
  logic          mem_empty;
  logic          load_mem;
  logic          push_mem;
  logic [OW-1:0] occ;
  logic [OW-1:0] occ_d;

  assign do_pop    = out_valid_q && pop_i;
  assign out_free  = !out_valid_q || do_pop;
  assign mem_empty = (mem_cnt_q == '0);
  assign load_mem  = out_free && !mem_empty;
  // An empty FIFO lets the incoming word go straight into the head register.
  assign push_mem  = push_i && !(out_free && mem_empty);

  assign occ   = mem_cnt_q + OW'(out_valid_q);
  assign occ_d = occ + OW'(push_i) - OW'(do_pop);

  assign full_next_o = (occ_d == OW'(DEPTH));
  assign valid_o     = out_valid_q;
  assign dout_o      = out_data_q;

  always_ff @(posedge clk) begin
    if (push_mem) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (push_mem) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (load_mem) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      mem_cnt_q <= mem_cnt_q + OW'(push_mem) - OW'(load_mem);
      if (load_mem) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mem_q[rd_ptr_q];
      end else if (out_free) begin
        out_valid_q <= push_i;
        if (push_i) begin
          out_data_q <= din_i;
        end
      end
    end
  end

endmodule : axi_bridge_rx_fifo
`default_nettype wire

// File: rtl/axi_bridge_ip_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module : axi_bridge_ip_rx -- link beats to AXI4-Stream with abort on bad beats
// Rev    : 1.0   Optional: AXI_BRIDGE_IP_RX_STATS_EN adds stat_pkts/stat_bytes
// ----------------------------------------------------------------------------
module axi_bridge_ip_rx
  import axi_bridge_ip_rx_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int NBYTES     = DATA_W / 8,
  parameter int CNT_W      = $clog2(NBYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lnk_valid,
  output logic              lnk_ready,
  input  logic [DATA_W-1:0] lnk_data,
  input  logic [CNT_W-1:0]  lnk_nbytes,
  input  logic              lnk_last,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [NBYTES-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              err_sticky,
  output logic [15:0]       err_cnt
`ifdef AXI_BRIDGE_IP_RX_STATS_EN
  ,
  output logic [31:0]       stat_pkts,
  output logic [47:0]       stat_bytes
`endif
);

  localparam int FW = DATA_W + NBYTES + 2;

  rx_state_e   state_q;
  logic        lnk_ready_q;
  logic        err_sticky_q;
  logic [15:0] err_cnt_q;

  logic                 accept;
  logic                 illegal;
  logic                 push;
  logic                 drop_next;
  logic [MAX_CNT_W-1:0] nb_ext;
  logic [MAX_CNT_W-1:0] nb_clamp;
  logic [NBYTES-1:0]    keep;
  rx_beat_t             ctl;
  logic [FW-1:0]        fifo_din;
  logic [FW-1:0]        fifo_dout;
  logic                 fifo_valid;
  logic                 fifo_full_next;

  assign accept   = lnk_valid && lnk_ready_q;
  assign nb_ext   = MAX_CNT_W'(lnk_nbytes);
  assign illegal  = nbytes_illegal_f(nb_ext, NBYTES, lnk_last);
  assign nb_clamp = (nb_ext == '0) ? MAX_CNT_W'(1) : nb_ext;
  assign keep     = NBYTES'(keep_from_nbytes(nb_clamp, NBYTES));

  // A bad beat becomes a one-beat terminator so downstream sees tlast+tuser.
  assign ctl.tuser = illegal;
  assign ctl.tlast = lnk_last || illegal;
  assign fifo_din  = {ctl, keep, lnk_data};
  assign push      = accept && (state_q != DROP);

  assign drop_next = accept ? ((state_q == DROP) ? !lnk_last : (illegal && !lnk_last))
                            : (state_q == DROP);

  axi_bridge_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .din_i       (fifo_din),
    .pop_i       (m_axis_tready),
    .dout_o      (fifo_dout),
    .valid_o     (fifo_valid),
    .full_next_o (fifo_full_next)
  );

  // Ready is registered from the post-update occupancy, so tready only reaches a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lnk_ready_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= 16'd0;
    end else begin
      lnk_ready_q <= drop_next || !fifo_full_next;
      if (accept) begin
        case (state_q)
          IDLE, IN_PKT: begin
            if (illegal) begin
              state_q      <= lnk_last ? IDLE : DROP;
              err_sticky_q <= 1'b1;
              if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
              end
            end else begin
              state_q <= lnk_last ? IDLE : IN_PKT;
            end
          end
          DROP: begin
            if (lnk_last) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign lnk_ready     = lnk_ready_q;
  assign err_sticky    = err_sticky_q;
  assign err_cnt       = err_cnt_q;
  assign m_axis_tvalid = fifo_valid;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_dout;

`ifdef AXI_BRIDGE_IP_RX_STATS_EN
  logic [31:0] stat_pkts_q;
  logic [47:0] stat_bytes_q;
  logic        good_hs;

  assign good_hs = m_axis_tvalid && m_axis_tready && !m_axis_tuser;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts_q  <= 32'd0;
      stat_bytes_q <= 48'd0;
    end else if (good_hs) begin
      stat_bytes_q <= stat_bytes_q + 48'($countones(m_axis_tkeep));
      if (m_axis_tlast) begin
        stat_pkts_q <= stat_pkts_q + 32'd1;
      end
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_bytes = stat_bytes_q;
`else
  // Statistics build option disabled: no counters or ports.
`endif

endmodule : axi_bridge_ip_rx
`default_nettype wire

// File: tb/tb_axi_bridge_ip_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_axi_bridge_ip_rx -- scoreboard bench for axi_bridge_ip_rx (DATA_W=64)
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_axi_bridge_ip_rx;

  localparam int DATA_W = 64;
  localparam int NBYTES = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              lnk_valid;
  logic              lnk_ready;
  logic [DATA_W-1:0] lnk_data;
  logic [CNT_W-1:0]  lnk_nbytes;
  logic              lnk_last;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [NBYTES-1:0] m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic              err_sticky;
  logic [15:0]       err_cnt;
`ifdef AXI_BRIDGE_IP_RX_STATS_EN
  logic [31:0]       stat_pkts;
  logic [47:0]       stat_bytes;
`endif

  always #5 clk = ~clk;

  axi_bridge_ip_rx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lnk_valid     (lnk_valid),
    .lnk_ready     (lnk_ready),
    .lnk_data      (lnk_data),
    .lnk_nbytes    (lnk_nbytes),
    .lnk_last      (lnk_last),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .err_sticky    (err_sticky),
    .err_cnt       (err_cnt)
`ifdef AXI_BRIDGE_IP_RX_STATS_EN
    ,
    .stat_pkts     (stat_pkts),
    .stat_bytes    (stat_bytes)
`endif
  );

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
  } exp_t;

  exp_t sb_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   m_state  = 0;  // 0 idle, 1 in packet, 2 dropping
  int   accepts  = 0;

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] exp_keep(input int nb);
    if (nb >= 8) return 8'hFF;
    if (nb == 0) return 8'h01;
    return 8'((1 << nb) - 1);
  endfunction

  task automatic model_accept(input logic [63:0] d, input int nb, input bit last);
    bit   bad;
    exp_t e;
    bad = (nb == 0) || (nb > 8) || (!last && (nb != 8));
    accepts++;
    if (m_state == 2) begin
      if (last) m_state = 0;
    end else if (bad) begin
      e = {1'b1, 1'b1, exp_keep(nb), d};
      sb_q.push_back(e);
      m_state = last ? 0 : 2;
    end else begin
      e = {1'b0, last, exp_keep(nb), d};
      sb_q.push_back(e);
      m_state = last ? 0 : 1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input int nb, input bit last);
    int n;
    lnk_valid  = 1'b1;
    lnk_data   = d;
    lnk_nbytes = CNT_W'(nb);
    lnk_last   = last;
    n = 0;
    @(negedge clk);
    while (!lnk_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!lnk_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: lnk_ready=%b required 1", lnk_ready);
    end else begin
      model_accept(d, nb, last);
      @(posedge clk);
    end
    #1;
    lnk_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || m_axis_tvalid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (sb_q.size() == 0) && !m_axis_tvalid;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expectation per AXIS handshake.
  initial begin : monitor
    exp_t got;
    exp_t prev_beat;
    exp_t e;
    bit   prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        got = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (prev_stall) begin
          checks++;
          if (!m_axis_tvalid || got !== prev_beat) begin
            errors++;
            $display("FAIL axis_hold: got v=%b %h required v=1 %h", m_axis_tvalid, got, prev_beat);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h required no beat", got);
          end else begin
            e = sb_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL beat: got %h required %h", got, e);
            end
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = got;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid); end
    checks++; if (lnk_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", lnk_ready); end
    checks++; if ({m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== 74'd0) begin
      errors++; $display("FAIL rst_data: got %h required 0", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
    end
    checks++; if (err_sticky !== 1'b0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_err: got sticky=%b cnt=%0d required 0/0", err_sticky, err_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (lnk_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b required 1", lnk_ready); end
  endtask

  task automatic test_legal();
    bit ok;
    m_axis_tready = 1'b1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL legal_idle: got %b required 0", m_axis_tvalid); end
    send_beat(rnd64(), 8, 1'b0);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL legal_latency: got %b required 1", m_axis_tvalid); end
    send_beat(rnd64(), 8, 1'b0);
    send_beat(rnd64(), 3, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL legal_drain: left=%0d required 0", sb_q.size()); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL legal_err: got %0d required 0", err_cnt); end
  endtask

  task automatic test_back_to_back();
    bit  ok;
    time t0;
    m_axis_tready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 8; i++) send_beat(rnd64(), (i == 7) ? 5 : 8, i == 7);
    checks++; if (($time - t0) !== 80) begin errors++; $display("FAIL b2b_rate: got %0t required 80", $time - t0); end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: left=%0d required 0", sb_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int a0;
    a0 = accepts;
    m_axis_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(rnd64(), (i == 5) ? 3 : 8, i == 5);
      end
      begin
        repeat (10) @(negedge clk);
        checks++; if (accepts - a0 !== 4) begin errors++; $display("FAIL bp_accepts: got %0d required 4", accepts - a0); end
        checks++; if (lnk_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b required 0", lnk_ready); end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        checks++; if (lnk_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle: got %b required 0", lnk_ready); end
        @(negedge clk);
        checks++; if (lnk_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: got %b required 1", lnk_ready); end
      end
    join
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: left=%0d required 0", sb_q.size()); end
  endtask

  task automatic test_illegal_mid();
    bit ok;
    m_axis_tready = 1'b1;
    send_beat(rnd64(), 8, 1'b0);
    send_beat(rnd64(), 5, 1'b0);
    send_beat(rnd64(), 8, 1'b0);
    send_beat(rnd64(), 8, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ill_drain: left=%0d required 0", sb_q.size()); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL ill_cnt: got %0d required 1", err_cnt); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %b required 1", err_sticky); end
  endtask

  task automatic test_nbytes_bounds();
    bit ok;
    m_axis_tready = 1'b1;
    send_beat(rnd64(), 0, 1'b1);
    send_beat(rnd64(), 8, 1'b0);
    send_beat(rnd64(), 6, 1'b1);
    send_beat(rnd64(), 9, 1'b1);
    send_beat(rnd64(), 7, 1'b0);
    send_beat(rnd64(), 0, 1'b0);
    send_beat(rnd64(), 8, 1'b1);
    send_beat(rnd64(), 1, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bnd_drain: left=%0d required 0", sb_q.size()); end
    checks++; if (err_cnt !== 16'd4) begin errors++; $display("FAIL bnd_cnt: got %0d required 4", err_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(rnd64(), 8, 1'b0);
    #1;
    rst = 1'b1;
    sb_q.delete();
    m_state = 0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b required 0", m_axis_tvalid); end
    checks++; if (lnk_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b required 0", lnk_ready); end
    checks++; if (err_cnt !== 16'd0 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL rmid_err: got cnt=%0d sticky=%b required 0/0", err_cnt, err_sticky);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_empty: got %b required 0", m_axis_tvalid); end
    @(posedge clk); #1;
    send_beat(rnd64(), 4, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_drain: left=%0d required 0", sb_q.size()); end
  endtask

`ifdef AXI_BRIDGE_IP_RX_STATS_EN
  task automatic test_stats();
    bit ok;
    #1;
    rst = 1'b1;
    sb_q.delete();
    m_state = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    send_beat(rnd64(), 8, 1'b0);
    send_beat(rnd64(), 3, 1'b1);
    send_beat(rnd64(), 8, 1'b0);
    send_beat(rnd64(), 8, 1'b1);
    send_beat(rnd64(), 0, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stat_drain: left=%0d required 0", sb_q.size()); end
    checks++; if (stat_pkts !== 32'd2) begin errors++; $display("FAIL stat_pkts: got %0d required 2", stat_pkts); end
    checks++; if (stat_bytes !== 48'd27) begin errors++; $display("FAIL stat_bytes: got %0d required 27", stat_bytes); end
  endtask
`endif

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    lnk_valid     = 1'b0;
    lnk_data      = '0;
    lnk_nbytes    = '0;
    lnk_last      = 1'b0;
    m_axis_tready = 1'b1;
    test_reset();
    test_legal();
    test_back_to_back();
    test_backpressure();
    test_illegal_mid();
    test_nbytes_bounds();
    test_reset_mid();
`ifdef AXI_BRIDGE_IP_RX_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_axi_bridge_ip_rx
`default_nettype wire
